// File: rtl/cond_pkg.sv
// cond_pkg: shared condition-code encodings and NZCV bit positions
// used by the condition unit and any later hazard logic.
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0,
      NE = 4'h1,
      CS = 4'h2,
      CC = 4'h3,
      MI = 4'h4,
      PL = 4'h5,
      VS = 4'h6,
      VC = 4'h7,
      HI = 4'h8,
      LS = 4'h9,
      GE = 4'hA,
      LT = 4'hB,
      GT = 4'hC,
      LE = 4'hD,
      AL = 4'hE,
      NV = 4'hF
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// cond_check: combinational evaluation of a 4-bit condition field
// against an NZCV flag vector.
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   always_comb begin
      CondEx = 1'b0;
      case (cond_e'(Cond))
         EQ:      CondEx = z;
         NE:      CondEx = ~z;
         CS:      CondEx = c;
         CC:      CondEx = ~c;
         MI:      CondEx = n;
         PL:      CondEx = ~n;
         VS:      CondEx = v;
         VC:      CondEx = ~v;
         HI:      CondEx = c & ~z;
         LS:      CondEx = ~c | z;
         GE:      CondEx = ~(n ^ v);
         LT:      CondEx = n ^ v;
         GT:      CondEx = ~z & ~(n ^ v);
         LE:      CondEx = z | (n ^ v);
         AL:      CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register plus condition gating of PC/reg/mem writes.
// Define COND_SQUASH_CNT_EN to add the saturating squash counter.
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 16
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             InstrValid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
`ifdef COND_SQUASH_CNT_EN
  input  logic             StatClr,
  output logic [CNT_W-1:0] SquashCnt,
`endif
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex;
  logic       fire;

  cond_check u_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  assign fire = InstrValid & cond_ex;

  always_comb begin
    flags_d = flags_q;
    if (fire & FlagW[FLAGW_NZ]) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (fire & FlagW[FLAGW_CV]) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flags_q <= '0;
    else          flags_q <= flags_d;
  end

  assign CondEx   = cond_ex;
  assign PCSrc    = PCS  & fire & reset_n;
  assign RegWrite = RegW & fire & reset_n;
  assign MemWrite = MemW & fire & reset_n;
  assign Flags    = flags_q;

`ifdef COND_SQUASH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (StatClr)
      cnt_d = '0;
    else if (InstrValid & ~cond_ex & ~&cnt_q)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign SquashCnt = cnt_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed vectors for cond_unit, checked against a
// behavioural flag/condition model on every falling clock edge.
module tb_cond_unit;

  logic       clk;
  logic       reset_n;
  logic       InstrValid;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW;
  logic       CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0] Flags;
`ifdef COND_SQUASH_CNT_EN
  logic       StatClr;
  logic [3:0] SquashCnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  cond_unit #(.CNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .InstrValid (InstrValid),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
`ifdef COND_SQUASH_CNT_EN
    .StatClr    (StatClr),
    .SquashCnt  (SquashCnt),
`endif
    .CondEx     (CondEx),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .Flags      (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic passes(input logic [3:0] cc,
                                  input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  logic [3:0] m_flags;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      m_flags <= 4'b0000;
    else if (InstrValid && passes(Cond, m_flags)) begin
      if (FlagW[1]) m_flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) m_flags[1:0] <= ALUFlags[1:0];
    end
  end

  always @(negedge clk) begin
    logic ok;
    ok = InstrValid && passes(Cond, m_flags) && reset_n;
    chk("m_flags", 32'(Flags), 32'(m_flags));
    chk("m_condex", 32'(CondEx), 32'(passes(Cond, m_flags)));
    chk("m_pcsrc", 32'(PCSrc), 32'(PCS && ok));
    chk("m_regwrite", 32'(RegWrite), 32'(RegW && ok));
    chk("m_memwrite", 32'(MemWrite), 32'(MemW && ok));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    InstrValid = 1'b1;
    Cond       = 4'hE;
    ALUFlags   = 4'h0;
    FlagW      = 2'b00;
    PCS        = 1'b0;
    RegW       = 1'b1;
    MemW       = 1'b0;
`ifdef COND_SQUASH_CNT_EN
    StatClr    = 1'b0;
`endif
    step();
    #2;
    chk("rst_flags", 32'(Flags), 32'h0);
    chk("rst_condex", 32'(CondEx), 32'h1);
    chk("rst_regwrite", 32'(RegWrite), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("al_regwrite", 32'(RegWrite), 32'h1);
    step();
    Cond = 4'h0;
    #2;
    chk("eq0_condex", 32'(CondEx), 32'h0);
    chk("eq0_regwrite", 32'(RegWrite), 32'h0);
    step();

    Cond = 4'hE; ALUFlags = 4'b0100; FlagW = 2'b10;
    step();
    Cond = 4'h0; FlagW = 2'b00;
    #2;
    chk("nz_flags", 32'(Flags), 32'h4);
    chk("nz_eq", 32'(CondEx), 32'h1);
    ALUFlags = 4'b0011; FlagW = 2'b01;
    step();
    FlagW = 2'b00; Cond = 4'h8;
    #2;
    chk("cv_flags", 32'(Flags), 32'h7);
    chk("hi_condex", 32'(CondEx), 32'h0);
    step();
    Cond = 4'h9;
    #2;
    chk("ls_condex", 32'(CondEx), 32'h1);
    step();

    Cond = 4'hE; ALUFlags = 4'b0100; FlagW = 2'b11;
    step();
    Cond = 4'h1; ALUFlags = 4'b1001; MemW = 1'b1;
    #2;
    chk("ne_memwrite", 32'(MemWrite), 32'h0);
    step();
    chk("ne_flags_hold", 32'(Flags), 32'h4);
    MemW = 1'b0; RegW = 1'b0;

    for (int f = 0; f < 16; f++) begin
      Cond = 4'hE; ALUFlags = 4'(f); FlagW = 2'b11;
      step();
      FlagW = 2'b00;
      #1;
      chk("sweep_load", 32'(Flags), 32'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #2;
        if (f == 9 && c == 10)
          chk("ge_n1v1", 32'(CondEx), 32'h1);
        if (f == 9 && c == 11)
          chk("lt_n1v1", 32'(CondEx), 32'h0);
        if (f == 8 && c == 10)
          chk("ge_n1v0", 32'(CondEx), 32'h0);
        if (f == 8 && c == 11)
          chk("lt_n1v0", 32'(CondEx), 32'h1);
        if (c == 15)
          chk("nv_never", 32'(CondEx), 32'h0);
        step();
      end
    end

    InstrValid = 1'b0; PCS = 1'b1; FlagW = 2'b11;
    ALUFlags = 4'b0000; Cond = 4'hE;
    #2;
    chk("bub_pcsrc", 32'(PCSrc), 32'h0);
    step();
    chk("bub_flags", 32'(Flags), 32'hF);

    InstrValid = 1'b1; RegW = 1'b1; ALUFlags = 4'b0101;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_flags", 32'(Flags), 32'h0);
    chk("mid_rst_regw", 32'(RegWrite), 32'h0);
    chk("mid_rst_pcsrc", 32'(PCSrc), 32'h0);
    step();
    chk("mid_rst_hold", 32'(Flags), 32'h0);
    reset_n = 1'b1;
    FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0;
    step();

`ifdef COND_SQUASH_CNT_EN
    Cond = 4'hF; StatClr = 1'b1;
    step();
    StatClr = 1'b0;
    chk("sq_clr0", 32'(SquashCnt), 32'h0);
    repeat (3) step();
    chk("sq_three", 32'(SquashCnt), 32'h3);
    repeat (17) step();
    chk("sq_sat", 32'(SquashCnt), 32'hF);
    StatClr = 1'b1;
    step();
    StatClr = 1'b0;
    chk("sq_clr_pri", 32'(SquashCnt), 32'h0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
